// File: rtl/buf_ram_2p_lane_be.sv
// rtl/buf_ram_2p_lane_be.sv - two-port pixel buffer with lane-group write enables, forwarding and valid tracking
module buf_ram_2p_lane_be #(
  parameter int PIX_W  = 8,
  parameter int LANES  = 8,
  parameter int GRPS   = 2,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic [GRPS-1:0]          a_we,
  input  logic [ADDR_W-1:0]        a_addr,
  input  logic [PIX_W*LANES-1:0]   a_data_i,
  input  logic                     b_re,
  input  logic [ADDR_W-1:0]        b_addr,
  output logic [PIX_W*LANES-1:0]   b_data_o,
  output logic                     b_valid_o,
  output logic [GRPS-1:0]          b_gvld_o
);

  localparam int DW = PIX_W * LANES;
  localparam int GL = LANES / GRPS;
  localparam int GW = GL * PIX_W;
  // DEPTH widened by one bit so the range compare works even when DEPTH == 2**ADDR_W
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  if (LANES % GRPS != 0) begin : g_chk_lanes
    $error("buf_ram_2p_lane_be: LANES must be a multiple of GRPS");
  end
  if (DEPTH > (2 ** ADDR_W)) begin : g_chk_depth
    $error("buf_ram_2p_lane_be: DEPTH does not fit in ADDR_W address bits");
  end

  // Data array is never reset; the valid array alone decides what a read may return
  logic [DW-1:0]   mem   [DEPTH];
  logic [GRPS-1:0] vld_q [DEPTH];
  logic [GRPS-1:0] vld_d [DEPTH];

  logic [DW-1:0]   b_data_q, b_data_d;
  logic            b_valid_q, b_valid_d;
  logic [GRPS-1:0] b_gvld_q, b_gvld_d;

  logic [DW-1:0]   rd_data;
  logic [GRPS-1:0] rd_gvld;
  logic            a_in, b_in;

  assign a_in = ({1'b0, a_addr} < DEPTH_W);
  assign b_in = ({1'b0, b_addr} < DEPTH_W);

  // Port A group-masked write into the data array; out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (a_in) begin
      for (int g = 0; g < GRPS; g++) begin
        if (a_we[g]) begin
          mem[a_addr][g*GW +: GW] <= a_data_i[g*GW +: GW];
        end
      end
    end
  end

  // Next valid state: flush clears everything first, then same-edge writes re-mark their groups
  always_comb begin
    vld_d = vld_q;
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_d[i] = '0;
      end
    end
    if (a_in) begin
      for (int g = 0; g < GRPS; g++) begin
        if (a_we[g]) begin
          vld_d[a_addr][g] = 1'b1;
        end
      end
    end
  end

  // Valid array register, cleared asynchronously so stale data never leaks after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
    end
  end

  // Per-group read select: same-cycle write forward, then flush, then stored valid data, else zero
  always_comb begin
    rd_data = '0;
    rd_gvld = '0;
    for (int g = 0; g < GRPS; g++) begin
      if (a_in && a_we[g] && (a_addr == b_addr)) begin
        rd_data[g*GW +: GW] = a_data_i[g*GW +: GW];
        rd_gvld[g]          = 1'b1;
      end else if (!flush_i && b_in && vld_q[b_addr][g]) begin
        rd_data[g*GW +: GW] = mem[b_addr][g*GW +: GW];
        rd_gvld[g]          = 1'b1;
      end
    end
  end

  // Output register next state: capture on read enable, otherwise hold the last word
  always_comb begin
    b_data_d  = b_data_q;
    b_gvld_d  = b_gvld_q;
    b_valid_d = b_re;
    if (b_re) begin
      b_data_d = rd_data;
      b_gvld_d = rd_gvld;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_data_q  <= '0;
      b_valid_q <= 1'b0;
      b_gvld_q  <= '0;
    end else begin
      b_data_q  <= b_data_d;
      b_valid_q <= b_valid_d;
      b_gvld_q  <= b_gvld_d;
    end
  end

  assign b_data_o  = b_data_q;
  assign b_valid_o = b_valid_q;
  assign b_gvld_o  = b_gvld_q;

endmodule

// File: tb/tb_buf_ram_2p_lane_be.sv
// tb/tb_buf_ram_2p_lane_be.sv - self-checking bench for buf_ram_2p_lane_be
module tb_buf_ram_2p_lane_be;

  logic         clk;
  logic         rst;
  logic         flush_i;
  logic [1:0]   a_we;
  logic [7:0]   a_addr;
  logic [63:0]  a_data_i;
  logic         b_re;
  logic [7:0]   b_addr;
  logic [63:0]  b_data_o;
  logic         b_valid_o;
  logic [1:0]   b_gvld_o;

  logic         p_flush;
  logic [3:0]   p_we;
  logic [7:0]   p_waddr;
  logic [159:0] p_wdata;
  logic         p_re;
  logic [7:0]   p_raddr;
  logic [159:0] p_data_o;
  logic         p_valid_o;
  logic [3:0]   p_gvld_o;

  buf_ram_2p_lane_be u_dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .a_we(a_we), .a_addr(a_addr), .a_data_i(a_data_i),
    .b_re(b_re), .b_addr(b_addr),
    .b_data_o(b_data_o), .b_valid_o(b_valid_o), .b_gvld_o(b_gvld_o)
  );

  buf_ram_2p_lane_be #(.PIX_W(10), .LANES(16), .GRPS(4), .DEPTH(208), .ADDR_W(8)) u_dut6 (
    .clk(clk), .rst(rst), .flush_i(p_flush),
    .a_we(p_we), .a_addr(p_waddr), .a_data_i(p_wdata),
    .b_re(p_re), .b_addr(p_raddr),
    .b_data_o(p_data_o), .b_valid_o(p_valid_o), .b_gvld_o(p_gvld_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference model: one byte per pixel lane, one valid flag per (word, group)
  logic [7:0]  m_pix [256][8];
  bit          m_vld [256][2];
  logic [63:0] exp_data;
  logic [1:0]  exp_gvld;
  logic        exp_valid;

  task automatic model_reset();
    for (int a = 0; a < 256; a++) begin
      m_vld[a][0] = 1'b0;
      m_vld[a][1] = 1'b0;
    end
    exp_data  = '0;
    exp_gvld  = '0;
    exp_valid = 1'b0;
  endtask

  // Predicts the outputs after the coming edge from the inputs now applied, then commits writes
  task automatic model_step();
    logic [63:0] w;
    logic [1:0]  gv;
    if (b_re) begin
      w  = '0;
      gv = '0;
      for (int l = 0; l < 8; l++) begin
        if (a_we[l/4] && a_addr == b_addr) begin
          w[l*8 +: 8] = a_data_i[l*8 +: 8];
          gv[l/4] = 1'b1;
        end else if (!flush_i && m_vld[b_addr][l/4]) begin
          w[l*8 +: 8] = m_pix[b_addr][l];
          gv[l/4] = 1'b1;
        end
      end
      exp_data = w;
      exp_gvld = gv;
    end
    exp_valid = b_re;
    if (flush_i) begin
      for (int a = 0; a < 256; a++) begin
        m_vld[a][0] = 1'b0;
        m_vld[a][1] = 1'b0;
      end
    end
    for (int l = 0; l < 8; l++) begin
      if (a_we[l/4]) begin
        m_pix[a_addr][l] = a_data_i[l*8 +: 8];
        m_vld[a_addr][l/4] = 1'b1;
      end
    end
  endtask

  // Compare process: every cycle, just after the active edge
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("b_valid_o", 160'(b_valid_o), 160'(exp_valid));
      chk("b_data_o", 160'(b_data_o), 160'(exp_data));
      chk("b_gvld_o", 160'(b_gvld_o), 160'(exp_gvld));
    end
  end

  task automatic step(input logic [1:0] we, input logic [7:0] wa, input logic [63:0] wd,
                      input logic re, input logic [7:0] ra, input logic fl);
    a_we = we; a_addr = wa; a_data_i = wd;
    b_re = re; b_addr = ra; flush_i = fl;
    model_step();
    @(negedge clk);
  endtask

  logic [159:0] d6, e6;

  initial begin
    rst = 1'b1; flush_i = 1'b0; a_we = '0; a_addr = '0; a_data_i = '0; b_re = 1'b0; b_addr = '0;
    p_flush = 1'b0; p_we = '0; p_waddr = '0; p_wdata = '0; p_re = 1'b0; p_raddr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_data", 160'(b_data_o), 160'd0);
    chk("rst_valid", 160'(b_valid_o), 160'd0);
    chk("rst_gvld", 160'(b_gvld_o), 160'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // 1) read of never-written word
    step(2'b00, 8'd0, 64'd0, 1'b1, 8'd5, 1'b0);
    chk("t1_valid", 160'(b_valid_o), 160'd1);
    chk("t1_data", 160'(b_data_o), 160'd0);
    chk("t1_gvld", 160'(b_gvld_o), 160'd0);

    // 2) group-wise writes
    step(2'b01, 8'd3, 64'h1122334455667788, 1'b0, 8'd0, 1'b0);
    step(2'b00, 8'd0, 64'd0, 1'b1, 8'd3, 1'b0);
    chk("t2_lo_data", 160'(b_data_o), 160'(64'h0000000055667788));
    chk("t2_lo_gvld", 160'(b_gvld_o), 160'(2'b01));
    step(2'b10, 8'd3, 64'h1122334455667788, 1'b0, 8'd0, 1'b0);
    step(2'b00, 8'd0, 64'd0, 1'b1, 8'd3, 1'b0);
    chk("t2_full_data", 160'(b_data_o), 160'(64'h1122334455667788));
    chk("t2_full_gvld", 160'(b_gvld_o), 160'(2'b11));

    // 3) same-cycle forwarding; different-address write alongside a read
    step(2'b11, 8'd7, 64'hA1A2A3A4A5A6A7A8, 1'b1, 8'd7, 1'b0);
    chk("t3_fwd_data", 160'(b_data_o), 160'(64'hA1A2A3A4A5A6A7A8));
    chk("t3_fwd_gvld", 160'(b_gvld_o), 160'(2'b11));
    step(2'b10, 8'd7, 64'hB1B2B3B4B5B6B7B8, 1'b1, 8'd7, 1'b0);
    chk("t3_mix_data", 160'(b_data_o), 160'(64'hB1B2B3B4A5A6A7A8));
    step(2'b10, 8'd11, 64'hB1B2B3B4B5B6B7B8, 1'b1, 8'd11, 1'b0);
    chk("t3_new_data", 160'(b_data_o), 160'(64'hB1B2B3B400000000));
    chk("t3_new_gvld", 160'(b_gvld_o), 160'(2'b10));
    step(2'b11, 8'd12, 64'hC0C0C0C0C0C0C0C0, 1'b1, 8'd11, 1'b0);
    step(2'b00, 8'd0, 64'd0, 1'b1, 8'd12, 1'b0);

    // 4) fill, flush while writing addr 9, read back everything
    for (int a = 0; a < 256; a++) begin
      step(2'b11, 8'(a), {8{8'(a)}}, 1'b0, 8'd0, 1'b0);
    end
    step(2'b11, 8'd9, 64'hDEADBEEFCAFEF00D, 1'b0, 8'd0, 1'b1);
    for (int a = 0; a < 256; a++) begin
      step(2'b00, 8'd0, 64'd0, 1'b1, 8'(a), 1'b0);
      if (a == 0) begin
        chk("t4_a0_data", 160'(b_data_o), 160'd0);
        chk("t4_a0_gvld", 160'(b_gvld_o), 160'd0);
      end
      if (a == 9) begin
        chk("t4_a9_data", 160'(b_data_o), 160'(64'hDEADBEEFCAFEF00D));
        chk("t4_a9_gvld", 160'(b_gvld_o), 160'(2'b11));
      end
    end
    // flush beats stored data, forward beats flush
    step(2'b00, 8'd0, 64'd0, 1'b1, 8'd9, 1'b1);
    chk("t4_flush_rd", 160'(b_gvld_o), 160'd0);
    step(2'b11, 8'd30, 64'h0F0E0D0C0B0A0908, 1'b1, 8'd30, 1'b1);
    chk("t4_fwd_flush", 160'(b_data_o), 160'(64'h0F0E0D0C0B0A0908));
    step(2'b00, 8'd0, 64'd0, 1'b1, 8'd9, 1'b0);

    // 5) hold behaviour and async reset mid-burst
    step(2'b11, 8'd20, 64'h0102030405060708, 1'b0, 8'd0, 1'b0);
    step(2'b00, 8'd0, 64'd0, 1'b1, 8'd20, 1'b0);
    chk("t5_v0", 160'(b_valid_o), 160'd1);
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 8'd0, 64'd0, 1'b0, 8'd20, 1'b0);
      chk("t5_vlow", 160'(b_valid_o), 160'd0);
      chk("t5_hold", 160'(b_data_o), 160'(64'h0102030405060708));
    end
    step(2'b00, 8'd0, 64'd0, 1'b1, 8'd20, 1'b0);
    rst = 1'b1;
    b_re = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_data", 160'(b_data_o), 160'd0);
    chk("t5_rst_valid", 160'(b_valid_o), 160'd0);
    chk("t5_rst_gvld", 160'(b_gvld_o), 160'd0);
    @(negedge clk);
    rst = 1'b0;
    step(2'b00, 8'd0, 64'd0, 1'b1, 8'd20, 1'b0);
    chk("t5_post_data", 160'(b_data_o), 160'd0);
    chk("t5_post_gvld", 160'(b_gvld_o), 160'd0);

    // 6) non-default parameters
    for (int l = 0; l < 16; l++) begin
      d6[l*10 +: 10] = 10'(l * 37 + 5);
    end
    e6 = '0;
    for (int l = 8; l < 12; l++) begin
      e6[l*10 +: 10] = d6[l*10 +: 10];
    end
    p_we = 4'b0100; p_waddr = 8'd207; p_wdata = d6; p_re = 1'b0;
    step(2'b00, 8'd0, 64'd0, 1'b0, 8'd0, 1'b0);
    p_we = 4'b0000; p_re = 1'b1; p_raddr = 8'd207;
    step(2'b00, 8'd0, 64'd0, 1'b0, 8'd0, 1'b0);
    chk("t6_207_data", p_data_o, e6);
    chk("t6_207_gvld", 160'(p_gvld_o), 160'(4'b0100));
    chk("t6_207_valid", 160'(p_valid_o), 160'd1);
    p_we = 4'b1111; p_waddr = 8'd208; p_wdata = '1; p_re = 1'b1; p_raddr = 8'd208;
    step(2'b00, 8'd0, 64'd0, 1'b0, 8'd0, 1'b0);
    chk("t6_208_fwd_data", p_data_o, 160'd0);
    chk("t6_208_fwd_gvld", 160'(p_gvld_o), 160'd0);
    p_we = 4'b0000; p_raddr = 8'd208;
    step(2'b00, 8'd0, 64'd0, 1'b0, 8'd0, 1'b0);
    chk("t6_208_data", p_data_o, 160'd0);
    chk("t6_208_gvld", 160'(p_gvld_o), 160'd0);
    p_raddr = 8'd207;
    step(2'b00, 8'd0, 64'd0, 1'b0, 8'd0, 1'b0);
    chk("t6_207_again", p_data_o, e6);
    p_re = 1'b0;
    step(2'b00, 8'd0, 64'd0, 1'b0, 8'd0, 1'b0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
